// File: rtl/hmm_obs_source.sv
// hmm_obs_source
//
// Purpose: generates one observation sequence for an HMM decoder under
// test. The true state path is turned into observations through an
// emission map, and each observation may be corrupted by a seeded LFSR.
// The source emits the observations, waits for the decoder to finish and
// then compares the decoded path against the true path.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   go                one-cycle request to emit a sequence (ignored while busy)
//   length            sequence length, 1..7 (0 reports len_err)
//   state_path_flat   true state for step t in bits [2t+1:2t]
//   emit_map_flat     observation for state s in bits [2s+1:2s]
//   noise_en          enables observation corruption
//   noise_thresh      corrupt when lfsr[7:0] < noise_thresh
//   seed              LFSR seed (0 is replaced by 16'hACE1)
//   start             decoder start pulse, carries obs[0] on obs_out
//   length_out        latched length presented to the decoder
//   obs_out           observation to the decoder
//   obs_valid         observation beat strobe for obs[1..length-1]
//   dec_done          decoder completion, sampled only while waiting
//   dec_path_flat     decoded path, same packing as state_path_flat
//   busy              sequence in progress
//   done              one-cycle completion pulse
//   match             decoded path equals the true path
//   mismatch_mask     bit t set when step t differs
//   flip_count        number of corrupted observations, saturates at 7
//   timeout           decoder did not finish within TIMEOUT cycles
//   len_err           requested length was 0
//
// TIMEOUT is expected to be at least 1 and below 65536.

module hmm_obs_source #(
   parameter int N       = 8,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           go,
   input  logic [2:0]     length,
   input  logic [2*N-1:0] state_path_flat,
   input  logic [7:0]     emit_map_flat,
   input  logic           noise_en,
   input  logic [7:0]     noise_thresh,
   input  logic [15:0]    seed,
   output logic           start,
   output logic [2:0]     length_out,
   output logic [1:0]     obs_out,
   output logic           obs_valid,
   input  logic           dec_done,
   input  logic [2*N-1:0] dec_path_flat,
   output logic           busy,
   output logic           done,
   output logic           match,
   output logic [N-1:0]   mismatch_mask,
   output logic [2:0]     flip_count,
   output logic           timeout,
   output logic           len_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_GAP,
      S_VALID,
      S_WAIT_DONE,
      S_REPORT
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       len_q, len_d;
   logic [2*N-1:0]   path_q, path_d;
   logic [7:0]       map_q, map_d;
   logic             noise_en_q, noise_en_d;
   logic [7:0]       thresh_q, thresh_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [2:0]       t_q, t_d;
   logic [15:0]      gap_q, gap_d;
   logic [15:0]      wait_q, wait_d;
   logic [1:0]       obs_q, obs_d;
   logic [2:0]       flip_q, flip_d;
   logic             match_q, match_d;
   logic [N-1:0]     mask_q, mask_d;
   logic             timeout_q, timeout_d;
   logic             len_err_q, len_err_d;

   logic [1:0]       step_state;
   logic [1:0]       base_obs;
   logic             corrupt;
   logic [1:0]       emit_obs;
   logic [15:0]      lfsr_next;
   logic [N-1:0]     cmp_mask;
   logic             last_step;

   // Observation datapath for the step currently being emitted. The
   // corruption decision uses the LFSR value before it advances, and the
   // mismatch mask only looks at steps inside the latched length.
   always_comb begin
      step_state = path_q[{t_q, 1'b0} +: 2];
      base_obs   = map_q[{step_state, 1'b0} +: 2];
      corrupt    = noise_en_q && (lfsr_q[7:0] < thresh_q);
      emit_obs   = base_obs;
      if (corrupt) begin
         emit_obs = (base_obs == 2'd2) ? 2'd0 : base_obs + 2'd1;
      end
      lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      last_step  = (t_q == len_q - 3'd1);
      cmp_mask   = '0;
      for (int i = 0; i < N; i++) begin
         cmp_mask[i] = (i < int'(len_q)) && (dec_path_flat[2*i +: 2] != path_q[2*i +: 2]);
      end
   end

   // Next-state and register update logic. Every register holds by default;
   // each state only touches what it owns. START and VALID are the only
   // states that emit an observation, so they alone advance the LFSR and
   // the step index.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      path_d     = path_q;
      map_d      = map_q;
      noise_en_d = noise_en_q;
      thresh_d   = thresh_q;
      lfsr_d     = lfsr_q;
      t_d        = t_q;
      gap_d      = gap_q;
      wait_d     = wait_q;
      obs_d      = obs_q;
      flip_d     = flip_q;
      match_d    = match_q;
      mask_d     = mask_q;
      timeout_d  = timeout_q;
      len_err_d  = len_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               len_d      = length;
               path_d     = state_path_flat;
               map_d      = emit_map_flat;
               noise_en_d = noise_en;
               thresh_d   = noise_thresh;
               lfsr_d     = (seed == 16'd0) ? 16'hACE1 : seed;
               t_d        = 3'd0;
               flip_d     = 3'd0;
               match_d    = 1'b0;
               mask_d     = '0;
               timeout_d  = 1'b0;
               len_err_d  = 1'b0;
               if (length == 3'd0) begin
                  len_err_d = 1'b1;
                  state_d   = S_REPORT;
               end else begin
                  state_d   = S_START;
               end
            end
         end

         S_START, S_VALID: begin
            obs_d  = emit_obs;
            lfsr_d = lfsr_next;
            t_d    = t_q + 3'd1;
            gap_d  = 16'd0;
            wait_d = 16'd0;
            if (corrupt && (flip_q != 3'd7)) begin
               flip_d = flip_q + 3'd1;
            end
            if (last_step) begin
               state_d = S_WAIT_DONE;
            end else if (GAP == 0) begin
               state_d = S_VALID;
            end else begin
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (gap_q == 16'(GAP - 1)) begin
               state_d = S_VALID;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end

         S_WAIT_DONE: begin
            if (dec_done) begin
               mask_d  = cmp_mask;
               match_d = (cmp_mask == '0);
               state_d = S_REPORT;
            end else if (wait_q + 16'd1 == 16'(TIMEOUT)) begin
               timeout_d = 1'b1;
               match_d   = 1'b0;
               mask_d    = '0;
               state_d   = S_REPORT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end

         S_REPORT: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything, including the
   // latched request, so an aborted sequence leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= 3'd0;
         path_q     <= '0;
         map_q      <= 8'd0;
         noise_en_q <= 1'b0;
         thresh_q   <= 8'd0;
         lfsr_q     <= 16'd0;
         t_q        <= 3'd0;
         gap_q      <= 16'd0;
         wait_q     <= 16'd0;
         obs_q      <= 2'd0;
         flip_q     <= 3'd0;
         match_q    <= 1'b0;
         mask_q     <= '0;
         timeout_q  <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         path_q     <= path_d;
         map_q      <= map_d;
         noise_en_q <= noise_en_d;
         thresh_q   <= thresh_d;
         lfsr_q     <= lfsr_d;
         t_q        <= t_d;
         gap_q      <= gap_d;
         wait_q     <= wait_d;
         obs_q      <= obs_d;
         flip_q     <= flip_d;
         match_q    <= match_d;
         mask_q     <= mask_d;
         timeout_q  <= timeout_d;
         len_err_q  <= len_err_d;
      end
   end

   // Output decode. Strobes come straight from the state; obs_out shows the
   // freshly computed observation during an emitting cycle and otherwise
   // holds the last emitted one.
   always_comb begin
      start         = (state_q == S_START);
      obs_valid     = (state_q == S_VALID);
      done          = (state_q == S_REPORT);
      busy          = (state_q != S_IDLE);
      obs_out       = (start || obs_valid) ? emit_obs : obs_q;
      length_out    = len_q;
      match         = match_q;
      mismatch_mask = mask_q;
      flip_count    = flip_q;
      timeout       = timeout_q;
      len_err       = len_err_q;
   end

endmodule

// File: tb/tb_hmm_obs_source.sv
// tb_hmm_obs_source
//
// Self-checking bench for hmm_obs_source. The bench plays the decoder,
// predicts every observation and result from the behavioural rules, and
// compares cycle by cycle, sampling on the falling edge.

module tb_hmm_obs_source;

   localparam int N       = 8;
   localparam int GAP     = 1;
   localparam int TIMEOUT = 255;

   logic           clk = 1'b0;
   logic           rst;
   logic           go;
   logic [2:0]     length;
   logic [2*N-1:0] state_path_flat;
   logic [7:0]     emit_map_flat;
   logic           noise_en;
   logic [7:0]     noise_thresh;
   logic [15:0]    seed;
   logic           start;
   logic [2:0]     length_out;
   logic [1:0]     obs_out;
   logic           obs_valid;
   logic           dec_done;
   logic [2*N-1:0] dec_path_flat;
   logic           busy;
   logic           done;
   logic           match;
   logic [N-1:0]   mismatch_mask;
   logic [2:0]     flip_count;
   logic           timeout;
   logic           len_err;

   int checks = 0;
   int errors = 0;

   logic [1:0] expObs [8];
   int         expFlipThru [8];

   hmm_obs_source #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .go              (go),
      .length          (length),
      .state_path_flat (state_path_flat),
      .emit_map_flat   (emit_map_flat),
      .noise_en        (noise_en),
      .noise_thresh    (noise_thresh),
      .seed            (seed),
      .start           (start),
      .length_out      (length_out),
      .obs_out         (obs_out),
      .obs_valid       (obs_valid),
      .dec_done        (dec_done),
      .dec_path_flat   (dec_path_flat),
      .busy            (busy),
      .done            (done),
      .match           (match),
      .mismatch_mask   (mismatch_mask),
      .flip_count      (flip_count),
      .timeout         (timeout),
      .len_err         (len_err)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Reference model: the full observation sequence and running flip count.
   task automatic buildModel(input logic [2:0] len, input logic [15:0] path, input logic [7:0] map,
                             input logic nz, input logic [7:0] thr, input logic [15:0] sd);
      logic [15:0] l;
      logic [1:0]  s;
      logic [1:0]  b;
      int          f;
      l = (sd == 16'd0) ? 16'hACE1 : sd;
      f = 0;
      for (int t = 0; t < 8; t++) begin
         expObs[t] = 2'd0;
         expFlipThru[t] = 0;
      end
      for (int t = 0; t < int'(len); t++) begin
         s = path[2*t +: 2];
         b = map[2*s +: 2];
         if (nz && (l[7:0] < thr)) begin
            expObs[t] = (b == 2'd2) ? 2'd0 : 2'(b + 2'd1);
            f = (f < 7) ? f + 1 : 7;
         end else begin
            expObs[t] = b;
         end
         expFlipThru[t] = f;
         l = lfsrStep(l);
      end
   endtask

   // Drives one go request for a single cycle with the given parameters.
   task automatic applyStimulus(input logic [2:0] len, input logic [15:0] path, input logic [7:0] map,
                                input logic nz, input logic [7:0] thr, input logic [15:0] sd);
      @(negedge clk);
      length          = len;
      state_path_flat = path;
      emit_map_flat   = map;
      noise_en        = nz;
      noise_thresh    = thr;
      seed            = sd;
      go              = 1'b1;
      @(negedge clk);
      go              = 1'b0;
   endtask

   task automatic checkAllZero(input string pfx);
      checkOutput({pfx, "_busy"}, busy, 0);
      checkOutput({pfx, "_start"}, start, 0);
      checkOutput({pfx, "_obs_valid"}, obs_valid, 0);
      checkOutput({pfx, "_done"}, done, 0);
      checkOutput({pfx, "_obs_out"}, obs_out, 0);
      checkOutput({pfx, "_length_out"}, length_out, 0);
      checkOutput({pfx, "_match"}, match, 0);
      checkOutput({pfx, "_mask"}, mismatch_mask, 0);
      checkOutput({pfx, "_flips"}, flip_count, 0);
      checkOutput({pfx, "_timeout"}, timeout, 0);
      checkOutput({pfx, "_len_err"}, len_err, 0);
   endtask

   // Runs one full sequence while acting as the decoder.
   // mode 0: dec_done respDelay cycles into the wait; mode 1: never;
   // mode 2: dec_done on the very cycle the timeout would expire.
   task automatic runSequence(input logic [2:0] len, input logic [15:0] path, input logic [7:0] map,
                              input logic nz, input logic [7:0] thr, input logic [15:0] sd,
                              input int mode, input int respDelay, input logic [15:0] decPath,
                              input logic strayDone, input logic busyGo);
      int         entryCyc;
      int         expDoneCyc;
      int         emitCount;
      int         lastEmit;
      int         startCount;
      int         validCount;
      bit         finished;
      logic [7:0] expMask;
      logic       expMatch;
      logic       expTimeout;
      logic       expLenErr;
      int         expFinalFlips;

      buildModel(len, path, map, nz, thr, sd);
      expMask = 8'd0;
      for (int t = 0; t < int'(len); t++) begin
         expMask[t] = (decPath[2*t +: 2] != path[2*t +: 2]);
      end
      expMatch      = (expMask == 8'd0);
      expTimeout    = 1'b0;
      expLenErr     = 1'b0;
      expFinalFlips = (len == 3'd0) ? 0 : expFlipThru[int'(len) - 1];
      if (len == 3'd0) begin
         expMask = 8'd0; expMatch = 1'b0; expLenErr = 1'b1;
      end else if (mode == 1) begin
         expMask = 8'd0; expMatch = 1'b0; expTimeout = 1'b1;
      end

      entryCyc   = -1;
      expDoneCyc = (len == 3'd0) ? 0 : -1;
      emitCount  = 0;
      lastEmit   = -100;
      startCount = 0;
      validCount = 0;
      finished   = 0;

      applyStimulus(len, path, map, nz, thr, sd);

      for (int cyc = 0; cyc < TIMEOUT + 60 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);

         if (start) begin
            startCount++;
            checkOutput("start_obs", obs_out, expObs[0]);
            checkOutput("length_out", length_out, len);
            emitCount++;
            lastEmit = cyc;
         end
         if (obs_valid) begin
            if (validCount + 1 < 8) checkOutput("beat_obs", obs_out, expObs[validCount + 1]);
            checkOutput("beat_spacing", cyc - lastEmit, GAP + 1);
            validCount++;
            emitCount++;
            lastEmit = cyc;
         end
         if (!start && !obs_valid && !done && emitCount > 0 && emitCount <= 8 && lastEmit == cyc - 1) begin
            checkOutput("flip_step", flip_count, expFlipThru[emitCount - 1]);
            checkOutput("obs_hold", obs_out, expObs[emitCount - 1]);
         end
         if (len != 3'd0 && entryCyc < 0 && emitCount == int'(len) && lastEmit == cyc) begin
            entryCyc   = cyc + 1;
            expDoneCyc = (mode == 0) ? entryCyc + respDelay + 1 : entryCyc + TIMEOUT;
         end

         if (done) begin
            checkOutput("done_cycle", cyc, expDoneCyc);
            checkOutput("match", match, expMatch);
            checkOutput("mismatch_mask", mismatch_mask, expMask);
            checkOutput("timeout", timeout, expTimeout);
            checkOutput("len_err", len_err, expLenErr);
            checkOutput("flip_count", flip_count, expFinalFlips);
            checkOutput("busy_in_report", busy, 1);
            checkOutput("start_pulses", startCount, (len == 3'd0) ? 0 : 1);
            checkOutput("valid_pulses", validCount, (len == 3'd0) ? 0 : int'(len) - 1);
            finished = 1;
         end

         dec_done = 1'b0;
         if (strayDone && cyc == 0 && len != 3'd0) begin
            dec_done      = 1'b1;
            dec_path_flat = ~path;
         end
         if (entryCyc >= 0 && !finished && mode != 1 && cyc == entryCyc + respDelay) begin
            dec_done      = 1'b1;
            dec_path_flat = decPath;
         end
         if (busyGo && cyc == 1) begin
            go              = 1'b1;
            length          = 3'd0;
            state_path_flat = ~path;
         end else begin
            go = 1'b0;
         end
      end

      checkOutput("done_seen", finished, 1);
      dec_done = 1'b0;
      go       = 1'b0;
      @(negedge clk);
      checkOutput("done_pulse_len", done, 0);
      checkOutput("busy_after", busy, 0);
      checkOutput("match_hold", match, expMatch);
      checkOutput("mask_hold", mismatch_mask, expMask);
      checkOutput("flips_hold", flip_count, expFinalFlips);
   endtask

   // Reset during a VALID beat must clear everything and produce no done.
   task automatic resetMidSequence();
      bit sawValid;
      int doneCount;
      sawValid  = 0;
      doneCount = 0;
      applyStimulus(3'd5, 16'h1B6C, 8'h9C, 1'b1, 8'hFF, 16'h1234);
      for (int i = 0; i < 20 && !sawValid; i++) begin
         if (i > 0) @(negedge clk);
         if (obs_valid) sawValid = 1;
      end
      checkOutput("rst_saw_valid", sawValid, 1);
      rst = 1'b1;
      @(negedge clk);
      checkAllZero("rst_mid");
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("no_done_after_rst", doneCount, 0);
   endtask

   initial begin
      rst             = 1'b1;
      go              = 1'b0;
      length          = 3'd0;
      state_path_flat = '0;
      emit_map_flat   = 8'd0;
      noise_en        = 1'b0;
      noise_thresh    = 8'd0;
      seed            = 16'd0;
      dec_done        = 1'b0;
      dec_path_flat   = '0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] scenario 1: clean length-3 sequence, matching decode");
      runSequence(3'd3, 16'h0024, 8'hE4, 1'b0, 8'h00, 16'h0000, 0, 2, 16'h0024, 1'b1, 1'b0);

      $display("[TB] scenario 2: decoder differs at step 0");
      runSequence(3'd3, 16'h0024, 8'hE4, 1'b0, 8'h00, 16'h0000, 0, 0, 16'h0025, 1'b0, 1'b0);

      $display("[TB] scenario 3: full noise, seed 1, length 7");
      runSequence(3'd7, 16'h2D93, 8'h4E, 1'b1, 8'hFF, 16'h0001, 0, 3, 16'h2D93, 1'b0, 1'b0);

      $display("[TB] scenario 4: decoder never finishes");
      runSequence(3'd3, 16'h0039, 8'hB1, 1'b0, 8'h00, 16'h0000, 1, 0, 16'h0000, 1'b0, 1'b0);

      $display("[TB] scenario 4b: dec_done on the expiry cycle");
      runSequence(3'd2, 16'h0006, 8'hE4, 1'b0, 8'h00, 16'h0000, 2, TIMEOUT - 1, 16'h0002, 1'b0, 1'b0);

      $display("[TB] scenario 5: length 1 and length 0");
      runSequence(3'd1, 16'h0003, 8'h6C, 1'b0, 8'h00, 16'h0000, 0, 1, 16'h0003, 1'b1, 1'b0);
      runSequence(3'd0, 16'h0024, 8'hE4, 1'b0, 8'h00, 16'h0000, 0, 0, 16'h0024, 1'b0, 1'b0);

      $display("[TB] scenario 6: reset mid-sequence, then go while busy");
      resetMidSequence();
      runSequence(3'd4, 16'h00E4, 8'hE4, 1'b1, 8'h80, 16'h0000, 0, 1, 16'h00E4, 1'b0, 1'b1);

      $display("[TB] randomized sequences");
      for (int k = 0; k < 16; k++) begin
         logic [2:0]  rLen;
         logic [15:0] rPath;
         logic [15:0] rDec;
         logic [15:0] rSeed;
         rLen  = 3'($urandom_range(0, 7));
         rPath = 16'($urandom);
         rSeed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         rDec  = rPath;
         if ($urandom_range(0, 1) == 1) rDec = rPath ^ (16'd1 << (2 * $urandom_range(0, 7)));
         runSequence(rLen, rPath, 8'($urandom), 1'($urandom), 8'($urandom), rSeed,
                     0, $urandom_range(0, 5), rDec, 1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
